// File: rtl/life_pkg.sv
// Shared types and constants for the streaming Game-of-Life row engine.
// Holds the standard B3/S23 masks, the frame-sequencing state type and the rule lookup.
package life_pkg;

    localparam logic [8:0] LIFE_B3  = 9'b0_0000_1000;
    localparam logic [8:0] LIFE_S23 = 9'b0_0000_1100;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        FLUSH
    } life_state_e;

    // Masks are widened to 16 bits so a 4-bit count can index them without a range hole.
    function automatic logic rule_lookup(
        input logic       cur,
        input logic [3:0] count,
        input logic [8:0] birth,
        input logic [8:0] survive
    );
        logic [15:0] w_birth_ext;
        logic [15:0] w_survive_ext;
        w_birth_ext   = {7'b0, birth};
        w_survive_ext = {7'b0, survive};
        return cur ? w_survive_ext[count] : w_birth_ext[count];
    endfunction

endpackage

// File: rtl/life_cell_rule.sv
// Next-state of one cell from its 3x3 neighbourhood and the active birth/survive masks.
// Bit 0 of each row slice is the left neighbour column, bit 2 the right one.
module life_cell_rule
    import life_pkg::*;
(
    input  logic [2:0] i_top,
    input  logic [2:0] i_mid,
    input  logic [2:0] i_bot,
    input  logic [8:0] i_birth,
    input  logic [8:0] i_survive,
    output logic       o_next
);

    logic [3:0] w_count;

    always_comb begin
        w_count = 4'(i_top[0]) + 4'(i_top[1]) + 4'(i_top[2])
                + 4'(i_mid[0])                + 4'(i_mid[2])
                + 4'(i_bot[0]) + 4'(i_bot[1]) + 4'(i_bot[2]);
        o_next  = rule_lookup(i_mid[1], w_count, i_birth, i_survive);
    end

endmodule

// File: rtl/life_row_stream_engine.sv
// Streaming next-generation row engine: a two-row window (top, mid) plus the incoming row
// forms the neighbourhood; each accepted row emits the next generation of the row above it.
module life_row_stream_engine
    import life_pkg::*;
#(
    parameter int unsigned ROW_LENGTH = 1280,
    parameter int unsigned MAX_ROWS   = 720,
    parameter int unsigned IDX_W      = $clog2(MAX_ROWS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ROW_LENGTH-1:0] in_row,
    input  logic                  in_first,
    input  logic                  in_last,
    input  logic [8:0]            birth_mask,
    input  logic [8:0]            survive_mask,
    input  logic                  wrap_h,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROW_LENGTH-1:0] out_row,
    output logic [IDX_W-1:0]      out_row_idx,
    output logic                  out_last,
    output logic                  frame_changed
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(MAX_ROWS - 1);

    life_state_e           r_state;
    life_state_e           w_state_nxt;

    logic [ROW_LENGTH-1:0] r_top;
    logic [ROW_LENGTH-1:0] r_mid;
    logic [8:0]            r_birth;
    logic [8:0]            r_survive;
    logic                  r_wrap;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_changed;

    logic                  r_out_valid;
    logic [ROW_LENGTH-1:0] r_out_row;
    logic [IDX_W-1:0]      r_out_idx;
    logic                  r_out_last;
    logic                  r_frame_changed;

    logic                  w_out_free;
    logic                  w_in_ready;
    logic                  w_accept;
    logic                  w_emit;
    logic                  w_emit_last;
    logic                  w_restart;
    logic [ROW_LENGTH-1:0] w_bot;
    logic [ROW_LENGTH-1:0] w_next;
    logic                  w_diff;
    logic [ROW_LENGTH+1:0] w_top_ext;
    logic [ROW_LENGTH+1:0] w_mid_ext;
    logic [ROW_LENGTH+1:0] w_bot_ext;

    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = (r_state != FLUSH) && w_out_free;
    assign w_accept   = in_valid && w_in_ready;

    // The row below the last row of a frame is a dead border.
    assign w_bot = (r_state == FLUSH) ? '0 : in_row;

    // Each row is padded by one column per side: wrapped neighbour or dead cell.
    assign w_top_ext = {r_wrap & r_top[0], r_top, r_wrap & r_top[ROW_LENGTH-1]};
    assign w_mid_ext = {r_wrap & r_mid[0], r_mid, r_wrap & r_mid[ROW_LENGTH-1]};
    assign w_bot_ext = {r_wrap & w_bot[0], w_bot, r_wrap & w_bot[ROW_LENGTH-1]};

    for (genvar c = 0; c < ROW_LENGTH; c++) begin : g_cell
        life_cell_rule u_rule (
            .i_top     (w_top_ext[c+2:c]),
            .i_mid     (w_mid_ext[c+2:c]),
            .i_bot     (w_bot_ext[c+2:c]),
            .i_birth   (r_birth),
            .i_survive (r_survive),
            .o_next    (w_next[c])
        );
    end

    assign w_diff = |(w_next ^ r_mid);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_emit_last = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && in_first) begin
                    w_restart   = 1'b1;
                    w_state_nxt = in_last ? FLUSH : FILL;
                end
            end
            FILL, RUN: begin
                if (w_accept) begin
                    if (in_first) begin
                        w_restart   = 1'b1;
                        w_state_nxt = in_last ? FLUSH : FILL;
                    end else begin
                        w_emit      = 1'b1;
                        w_state_nxt = in_last ? FLUSH : RUN;
                    end
                end
            end
            FLUSH: begin
                if (w_out_free) begin
                    w_emit      = 1'b1;
                    w_emit_last = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_top           <= '0;
            r_mid           <= '0;
            r_birth         <= LIFE_B3;
            r_survive       <= LIFE_S23;
            r_wrap          <= 1'b0;
            r_idx           <= '0;
            r_changed       <= 1'b0;
            r_out_valid     <= 1'b0;
            r_out_row       <= '0;
            r_out_idx       <= '0;
            r_out_last      <= 1'b0;
            r_frame_changed <= 1'b0;
        end else begin
            if (w_restart) begin
                r_top     <= '0;
                r_mid     <= in_row;
                r_birth   <= birth_mask;
                r_survive <= survive_mask;
                r_wrap    <= wrap_h;
                r_idx     <= '0;
                r_changed <= 1'b0;
            end else if (w_emit) begin
                r_top     <= w_emit_last ? '0 : r_mid;
                r_mid     <= w_emit_last ? '0 : in_row;
                r_changed <= r_changed | w_diff;
                if (r_idx != IDX_MAX) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
            end

            if (w_emit) begin
                r_out_valid     <= 1'b1;
                r_out_row       <= w_next;
                r_out_idx       <= r_idx;
                r_out_last      <= w_emit_last;
                r_frame_changed <= w_emit_last & (r_changed | w_diff);
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign out_row       = r_out_row;
    assign out_row_idx   = r_out_idx;
    assign out_last      = r_out_last;
    assign frame_changed = r_frame_changed;

endmodule

// File: tb/tb_life_row_stream_engine.sv
// Self-checking bench for life_row_stream_engine with 8-cell rows and an 8-row index range.
// Known patterns come from a table; random frames are checked against a column-wise reference.
module tb_life_row_stream_engine;
    import life_pkg::*;

    localparam int unsigned L  = 8;
    localparam int unsigned MR = 8;
    localparam int unsigned IW = 3;

    typedef struct packed {
        logic [7:0] row;
        logic [2:0] idx;
        logic       last;
        logic       fc;
    } beat_t;

    typedef struct packed {
        logic [3:0]       n;
        logic [11:0][7:0] rows;
        logic [11:0][7:0] exp;
        logic [8:0]       bm;
        logic [8:0]       sm;
        logic             wrap;
        logic             chg;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [L-1:0]  in_row = '0;
    logic          in_first = 1'b0;
    logic          in_last = 1'b0;
    logic [8:0]    birth_mask = LIFE_B3;
    logic [8:0]    survive_mask = LIFE_S23;
    logic          wrap_h = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [L-1:0]  out_row;
    logic [IW-1:0] out_row_idx;
    logic          out_last;
    logic          frame_changed;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic        stall      = 1'b0;
    logic        rand_ready = 1'b0;
    beat_t       mon_q[$];
    beat_t       exp_q[$];

    life_row_stream_engine #(.ROW_LENGTH(L), .MAX_ROWS(MR), .IDX_W(IW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .in_first(in_first), .in_last(in_last),
        .birth_mask(birth_mask), .survive_mask(survive_mask), .wrap_h(wrap_h),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_row_idx(out_row_idx), .out_last(out_last), .frame_changed(frame_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = stall ? 1'b0 : (rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: records handshaken beats and checks that stalled outputs hold still.
    logic       have_stall = 1'b0;
    logic [7:0] st_row;
    logic [2:0] st_idx;
    logic       st_last;
    always @(negedge clk) begin
        if (rst) begin
            have_stall = 1'b0;
        end else begin
            if (have_stall && out_valid) begin
                chk("stall_row_stable", out_row, st_row);
                chk("stall_idx_stable", out_row_idx, st_idx);
                chk("stall_last_stable", out_last, st_last);
            end
            if (out_valid && out_ready)
                mon_q.push_back('{row: out_row, idx: out_row_idx, last: out_last, fc: frame_changed});
            have_stall = out_valid && !out_ready;
            st_row  = out_row;
            st_idx  = out_row_idx;
            st_last = out_last;
        end
    end

    // Reference: count neighbours column by column, folding out-of-range columns per wrap.
    function automatic logic [7:0] model_next(input logic [7:0] t, input logic [7:0] m,
                                              input logic [7:0] b, input logic [8:0] bm,
                                              input logic [8:0] sm, input logic w);
        logic [7:0] rr[3];
        logic [7:0] res;
        int cnt;
        int col;
        rr[0] = t; rr[1] = m; rr[2] = b;
        res = '0;
        for (int c = 0; c < 8; c++) begin
            cnt = 0;
            for (int dr = 0; dr < 3; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    if (dr == 1 && dc == 0) continue;
                    col = c + dc;
                    if (col < 0 || col > 7) begin
                        if (!w) continue;
                        col = (col + 8) % 8;
                    end
                    cnt += int'(rr[dr][col]);
                end
            end
            res[c] = m[c] ? sm[cnt] : bm[cnt];
        end
        return res;
    endfunction

    function automatic logic [2:0] sat_idx(input int unsigned r);
        return 3'((r > MR - 1) ? MR - 1 : r);
    endfunction

    task automatic model_push(input logic [11:0][7:0] rows, input int unsigned n,
                              input logic [8:0] bm, input logic [8:0] sm, input logic w);
        logic       chg;
        logic [7:0] o;
        logic [7:0] t;
        logic [7:0] b;
        chg = 1'b0;
        for (int unsigned r = 0; r < n; r++) begin
            t = (r > 0) ? rows[r-1] : 8'h00;
            b = (r + 1 < n) ? rows[r+1] : 8'h00;
            o = model_next(t, rows[r], b, bm, sm, w);
            chg = chg | (o != rows[r]);
            exp_q.push_back('{row: o, idx: sat_idx(r), last: (r == n - 1), fc: (r == n - 1) & chg});
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send_beat(input logic [7:0] row, input logic first, input logic last,
                             input logic [8:0] bm, input logic [8:0] sm, input logic w);
        int unsigned k;
        k = 0;
        in_valid = 1'b1; in_row = row; in_first = first; in_last = last;
        birth_mask = bm; survive_mask = sm; wrap_h = w;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            k++;
            if (k > 200) begin
                n_checks++; n_fail++;
                $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, required 1", k);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Masks/wrap on non-first beats are scrambled: the engine must use the latched copies.
    task automatic send_frame(input logic [11:0][7:0] rows, input int unsigned n,
                              input logic [8:0] bm, input logic [8:0] sm, input logic w);
        for (int unsigned i = 0; i < n; i++) begin
            if (i == 0) send_beat(rows[i], 1'b1, (n == 1), bm, sm, w);
            else        send_beat(rows[i], 1'b0, (i == n - 1), 9'($urandom), 9'($urandom), 1'($urandom));
        end
    endtask

    task automatic drain_check(input string name);
        int unsigned k;
        beat_t a;
        beat_t e;
        k = 0;
        while (mon_q.size() < exp_q.size() && k < 400) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        chk({name, "_beat_count"}, mon_q.size(), exp_q.size());
        while (exp_q.size() > 0 && mon_q.size() > 0) begin
            a = mon_q.pop_front();
            e = exp_q.pop_front();
            chk({name, "_row"}, a.row, e.row);
            chk({name, "_idx"}, a.idx, e.idx);
            chk({name, "_last"}, a.last, e.last);
            if (e.last) chk({name, "_frame_changed"}, a.fc, e.fc);
        end
        exp_q.delete();
        mon_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t             tbl[5];
        logic [11:0][7:0] rows;
        logic [11:0][7:0] rows_b;
        int unsigned      n;
        logic [8:0]       bm;
        logic [8:0]       sm;
        logic             w;

        for (int i = 0; i < 5; i++) begin
            tbl[i] = '0;
            tbl[i].bm = LIFE_B3;
            tbl[i].sm = LIFE_S23;
        end
        tbl[0].n = 5; tbl[0].rows[2] = 8'h1C;
        tbl[0].exp[1] = 8'h08; tbl[0].exp[2] = 8'h08; tbl[0].exp[3] = 8'h08; tbl[0].chg = 1'b1;
        tbl[1].n = 4; tbl[1].rows[1] = 8'h18; tbl[1].rows[2] = 8'h18;
        tbl[1].exp[1] = 8'h18; tbl[1].exp[2] = 8'h18; tbl[1].chg = 1'b0;
        tbl[2].n = 5; tbl[2].wrap = 1'b1;
        tbl[2].rows[1] = 8'h01; tbl[2].rows[2] = 8'h01; tbl[2].rows[3] = 8'h01;
        tbl[2].exp[2] = 8'h83; tbl[2].chg = 1'b1;
        tbl[3].n = 5; tbl[3].wrap = 1'b0;
        tbl[3].rows[1] = 8'h01; tbl[3].rows[2] = 8'h01; tbl[3].rows[3] = 8'h01;
        tbl[3].exp[2] = 8'h03; tbl[3].chg = 1'b1;
        tbl[4].n = 1; tbl[4].rows[0] = 8'hFF; tbl[4].exp[0] = 8'h7E; tbl[4].chg = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_row", out_row, 0);
        chk("rst_out_idx", out_row_idx, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_frame_changed", frame_changed, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // Non-first beats while idle are dropped without output
        send_beat(8'hFF, 1'b0, 1'b0, LIFE_B3, LIFE_S23, 1'b0);
        send_beat(8'h3C, 1'b0, 1'b1, LIFE_B3, LIFE_S23, 1'b0);

        for (int i = 0; i < 5; i++) begin
            rand_ready = (i % 2 == 1);
            for (int unsigned r = 0; r < tbl[i].n; r++)
                exp_q.push_back('{row: tbl[i].exp[r], idx: 3'(r), last: (r == tbl[i].n - 1),
                                  fc: (r == tbl[i].n - 1) & tbl[i].chg});
            send_frame(tbl[i].rows, tbl[i].n, tbl[i].bm, tbl[i].sm, tbl[i].wrap);
            drain_check($sformatf("table%0d", i));
        end

        // Downstream stall held for 10 cycles mid-frame
        rand_ready = 1'b0;
        rows = '0;
        for (int r = 0; r < 6; r++) rows[r] = 8'($urandom);
        model_push(rows, 6, LIFE_B3, LIFE_S23, 1'b0);
        @(negedge clk);
        stall = 1'b1;
        fork
            send_frame(rows, 6, LIFE_B3, LIFE_S23, 1'b0);
            begin : stall_ctl
                int unsigned k;
                k = 0;
                while (!out_valid && k < 50) begin
                    @(negedge clk);
                    k++;
                end
                for (int c = 0; c < 10; c++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_out_valid", out_valid, 1);
                end
                stall = 1'b0;
            end
        join
        drain_check("stall");

        // in_first mid-frame abandons the partial frame without a flush beat
        rows = '0;
        rows_b = '0;
        for (int r = 0; r < 3; r++) rows[r] = 8'($urandom);
        for (int r = 0; r < 4; r++) rows_b[r] = 8'($urandom);
        for (int unsigned r = 0; r < 2; r++)
            exp_q.push_back('{row: model_next((r > 0) ? rows[r-1] : 8'h00, rows[r], rows[r+1],
                                              LIFE_B3, LIFE_S23, 1'b1),
                              idx: 3'(r), last: 1'b0, fc: 1'b0});
        model_push(rows_b, 4, LIFE_B3, LIFE_S23, 1'b0);
        send_beat(rows[0], 1'b1, 1'b0, LIFE_B3, LIFE_S23, 1'b1);
        send_beat(rows[1], 1'b0, 1'b0, LIFE_B3, LIFE_S23, 1'b1);
        send_beat(rows[2], 1'b0, 1'b0, LIFE_B3, LIFE_S23, 1'b1);
        send_frame(rows_b, 4, LIFE_B3, LIFE_S23, 1'b0);
        drain_check("restart");

        // Reset during RUN with a stalled pending beat, then a still-life frame
        rows = '0;
        rows[0] = 8'h01; rows[1] = 8'h07; rows[2] = 8'h40;
        send_beat(rows[0], 1'b1, 1'b0, LIFE_B3, LIFE_S23, 1'b0);
        send_beat(rows[1], 1'b0, 1'b0, LIFE_B3, LIFE_S23, 1'b0);
        send_beat(rows[2], 1'b0, 1'b0, LIFE_B3, LIFE_S23, 1'b0);
        @(negedge clk);
        stall = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_row", out_row, 0);
        chk("midrst_out_idx", out_row_idx, 0);
        chk("midrst_out_last", out_last, 0);
        chk("midrst_frame_changed", frame_changed, 0);
        chk("midrst_in_ready", in_ready, 1);
        mon_q.delete();
        exp_q.delete();
        stall = 1'b0;
        @(posedge clk); #1;
        rows = '0;
        rows[0] = 8'h18; rows[1] = 8'h18;
        model_push(rows, 3, LIFE_B3, LIFE_S23, 1'b0);
        send_frame(rows, 3, LIFE_B3, LIFE_S23, 1'b0);
        drain_check("after_rst");

        // Random frames, including ones longer than the index range
        for (int f = 0; f < 24; f++) begin
            n = (f == 5) ? 11 : $urandom_range(1, 12);
            rows = '0;
            for (int unsigned r = 0; r < n; r++) rows[r] = 8'($urandom);
            bm = (f % 3 == 0) ? 9'($urandom) : LIFE_B3;
            sm = (f % 3 == 0) ? 9'($urandom) : LIFE_S23;
            w  = 1'($urandom);
            rand_ready = (f % 2 == 1);
            model_push(rows, n, bm, sm, w);
            send_frame(rows, n, bm, sm, w);
            drain_check($sformatf("rand%0d", f));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
